if_fetch_unit: RTL
==================

# if_fetch_unit

Instruction-fetch stage of the 5-stage RV32I pipeline, directly upstream of the IF/ID pipeline register. It owns the fetch PC, issues word requests to instruction memory over a request/grant + in-order response interface, and buffers returned instructions in a small FIFO. It presents one {pc, inst} pair per cycle to IF/ID and honours the hazard unit's stall and EX-stage branch/jump redirects.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset (bits [1:0] must be 0)
- DEPTH, 4, instruction FIFO depth and maximum in-flight + buffered instructions; power of 2, >= 2

- i_clk  in  1  clock
- i_reset_n  in  1  asynchronous, active-low reset
- i_stall  in  1  hazard-unit stall; same signal that holds IF/ID
- i_redirect  in  1  taken branch/jump from EX; also drives IF/ID flush
- i_redirect_pc  in  32  redirect target; bits [1:0] ignored (forced 0)
- o_imem_req  out  1  fetch request valid
- o_imem_addr  out  32  fetch word address
- i_imem_gnt  in  1  request accepted this cycle (only meaningful with o_imem_req)
- i_imem_rvalid  in  1  response valid; responses in request order, exactly one per grant, >= 1 cycle after grant
- i_imem_rdata  in  32  response instruction word
- IF_o_valid  out  1  IF_o_inst/IF_o_pc hold a real instruction
- IF_o_inst  out  32  instruction to IF/ID; 32'h0000_0013 (NOP) when !IF_o_valid
- IF_o_pc  out  32  PC of IF_o_inst

## Operation
- State: fetch_pc (next request address), head_pc (PC of FIFO head), FIFO of DEPTH x 32-bit words with count, outstanding counter (granted, response not yet returned), discard counter (stale responses still to drop). Counters are $clog2(DEPTH)+1 bits.
- Request: o_imem_req = !i_redirect && (outstanding + count < DEPTH); o_imem_addr = fetch_pc. On req && gnt: fetch_pc += 4, outstanding += 1.
- Response: on i_imem_rvalid, outstanding -= 1. If discard > 0: drop word, discard -= 1. Else if i_redirect: drop word. Else push i_imem_rdata into FIFO.
- Consume: pop = IF_o_valid && !i_stall && !i_redirect. On pop, head_pc += 4.
- Redirect (priority over stall and pop): FIFO emptied; fetch_pc <= {i_redirect_pc[31:2], 2'b00}; head_pc <= same; discard <= outstanding - i_imem_rvalid (all in-flight responses become stale). No request issued in the redirect cycle.
- Outputs: IF_o_valid = (count != 0); IF_o_inst = FIFO head or NOP; IF_o_pc = head_pc. Outputs depend only on registered state.
- PC arithmetic is 32-bit modulo; 32'hFFFF_FFFC + 4 wraps to 0 silently.
- Push and pop in the same cycle with count == DEPTH cannot occur (credit rule); push into full FIFO is a design error, flag with assertion.

## Timing
- Reset: fetch_pc = head_pc = RESET_PC, count = outstanding = discard = 0; IF_o_valid = 0, IF_o_inst = NOP, IF_o_pc = RESET_PC, o_imem_req = 1 from the first cycle, o_imem_addr = RESET_PC.
- Reset mid-operation clears all state immediately; instruction memory shares the reset, so no pre-reset responses arrive.
- Latency: grant in cycle N, rvalid in N+L (L >= 1), IF_o_valid in N+L+1.
- With L = 1 and DEPTH = 4, sustained throughput 1 instruction/cycle when unstalled and gnt always high.
- Redirect in cycle N: IF_o_valid = 0 in N+1; first request to target in N+1; first target instruction valid at N+1+L+1 at earliest (plus any stale responses drained).
- Stall: outputs held; requests continue until credit exhausted; responses still accepted (credit guarantees space).

## Test plan
- Reset, gnt=1, L=1, no stall -> requests 0x0,0x4,0x8...; IF_o_valid first high 2 cycles after reset release; IF_o_pc 0x0,0x4,0x8 on consecutive cycles with matching memory words.
- Stall held 6 cycles mid-stream, L=1 -> IF_o_inst/IF_o_pc frozen; o_imem_req drops once outstanding+count=4; after release PCs continue with no gap or duplicate.
- Redirect to 0x0000_0103 with 2 requests outstanding (L=3) -> fetch resumes at 0x100; both stale responses dropped; first valid output IF_o_pc=0x100 with word at 0x100.
- Redirect coincident with i_imem_rvalid and i_stall -> returning word dropped, discard = outstanding-1, stall ignored, IF_o_valid=0 next cycle.
- Back-to-back redirects (0x200 then 0x300 next cycle) -> no instruction from 0x200 ever appears at IF_o_*; first output pc 0x300.
- fetch_pc near 0xFFFF_FFF8 -> requests 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000; assert reset mid-stream -> outputs return to reset values immediately.

Source files
------------

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, issues word requests to instruction
// memory and buffers returned words in a small FIFO feeding the IF/ID register.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_stall,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_gnt,
    input  logic        i_imem_rvalid,
    input  logic [31:0] i_imem_rdata,
    output logic        IF_o_valid,
    output logic [31:0] IF_o_inst,
    output logic [31:0] IF_o_pc
);

    localparam int            PW      = $clog2(DEPTH);
    localparam int            CW      = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [31:0]   NOP     = 32'h0000_0013;

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   head_pc_q, head_pc_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] outstanding_q, outstanding_d;
    logic [CW-1:0] discard_q, discard_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [31:0]   fifo_mem [DEPTH];

    logic          valid;
    logic          req;
    logic          fire;
    logic          push;
    logic          pop;
    logic [CW:0]   credit;
    logic [31:0]   redirect_pc;

    // Credit covers both buffered and in-flight words, so every response has a slot.
    always_comb begin
        valid       = (count_q != '0);
        credit      = {1'b0, outstanding_q} + {1'b0, count_q};
        req         = !i_redirect && (credit < {1'b0, DEPTH_C});
        fire        = req && i_imem_gnt;
        push        = i_imem_rvalid && (discard_q == '0) && !i_redirect;
        pop         = valid && !i_stall && !i_redirect;
        redirect_pc = i_redirect_pc & 32'hFFFF_FFFC;
    end

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        head_pc_d     = head_pc_q;
        count_d       = count_q;
        discard_d     = discard_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        outstanding_d = outstanding_q + CW'(fire) - CW'(i_imem_rvalid);

        if (i_redirect) begin
            // Everything still in flight belongs to the squashed path.
            fetch_pc_d = redirect_pc;
            head_pc_d  = redirect_pc;
            count_d    = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            discard_d  = outstanding_q - CW'(i_imem_rvalid);
        end else begin
            if (fire) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
            if (i_imem_rvalid && (discard_q != '0)) begin
                discard_d = discard_q - CW'(1);
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d  = rd_ptr_q + PW'(1);
                head_pc_d = head_pc_q + 32'd4;
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            fetch_pc_q    <= RESET_PC;
            head_pc_q     <= RESET_PC;
            count_q       <= '0;
            outstanding_q <= '0;
            discard_q     <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            head_pc_q     <= head_pc_d;
            count_q       <= count_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= i_imem_rdata;
        end
    end

    assign o_imem_req  = req;
    assign o_imem_addr = fetch_pc_q;
    assign IF_o_valid  = valid;
    assign IF_o_inst   = valid ? fifo_mem[rd_ptr_q] : NOP;
    assign IF_o_pc     = head_pc_q;

    a_no_push_full: assert property (@(posedge i_clk) disable iff (!i_reset_n)
        push |-> (count_q != DEPTH_C));
    a_rsp_has_req: assert property (@(posedge i_clk) disable iff (!i_reset_n)
        i_imem_rvalid |-> (outstanding_q != '0));

endmodule
